// File: rtl/audio_pkg.sv
// Shared types and constants for the song sequencer and keyboard map.
// Holds FSM states, event field offsets, control register map, keycodes.
package audio_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        APPLY,
        WAIT
    } seq_state_t;

    localparam int KEY_LSB  = 0;
    localparam int SLOT_LSB = 8;
    localparam int LAST_BIT = 10;
    localparam int DUR_LSB  = 16;

    localparam logic [1:0] CTRL_REG  = 2'd0;
    localparam logic [1:0] TICK_REG  = 2'd1;
    localparam logic [1:0] STAT_REG  = 2'd2;
    localparam logic [1:0] ABORT_REG = 2'd3;

    localparam logic [7:0] KEY_A = 8'h04;
    localparam logic [7:0] KEY_S = 8'h16;
    localparam logic [7:0] KEY_D = 8'h07;
    localparam logic [7:0] KEY_F = 8'h09;

    typedef struct packed {
        logic [15:0] dur;
        logic        last;
        logic [1:0]  slot;
        logic [7:0]  key;
    } evt_t;

    // Reserved bits [15:11] are dropped here.
    function automatic evt_t unpack_evt(input logic [31:0] w);
        evt_t e;
        e.dur  = w[DUR_LSB +: 16];
        e.last = w[LAST_BIT];
        e.slot = w[SLOT_LSB +: 2];
        e.key  = w[KEY_LSB +: 8];
        return e;
    endfunction

endpackage

// File: rtl/song_sequencer_if.sv
// Host bus for the sequencer: event memory port and control register port.
// master = host (NIOS side), slave = sequencer.
interface song_sequencer_if #(
    parameter int AW = 6
);
    logic [AW-1:0] evt_address;
    logic          evt_write;
    logic [31:0]   evt_writedata;
    logic [31:0]   evt_readdata;
    logic [1:0]    ctrl_address;
    logic          ctrl_write;
    logic [31:0]   ctrl_writedata;
    logic [31:0]   ctrl_readdata;

    modport master (
        output evt_address, evt_write, evt_writedata,
        input  evt_readdata,
        output ctrl_address, ctrl_write, ctrl_writedata,
        input  ctrl_readdata
    );

    modport slave (
        input  evt_address, evt_write, evt_writedata,
        output evt_readdata,
        input  ctrl_address, ctrl_write, ctrl_writedata,
        output ctrl_readdata
    );
endinterface

// File: rtl/song_sequencer_tick.sv
// tick_gen: programmable period counter, 1-cycle tick pulse while enabled.
// Ports: CLK, RESET_N, clr (zero counter), en, period (0 acts as 1), tick.
module tick_gen #(
    parameter int W = 24
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] period,
    output logic         tick
);
    logic [W-1:0] cnt;
    logic [W-1:0] lim;

    assign lim  = (period == '0) ? '0 : period - W'(1);
    // >= so a period shrunk below the count fires on the next cycle.
    assign tick = en && (cnt >= lim);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end
endmodule

// File: rtl/song_sequencer.sv
// Note scheduler driving the 32-bit song keycode word from an event memory.
// Ports: CLK, RESET_N, bus (event + control slave), song (4 slots), busy.
module song_sequencer
    import audio_pkg::*;
#(
    parameter int EVENT_DEPTH = 64,
    parameter int TICK_W      = 24
) (
    input  logic              CLK,
    input  logic              RESET_N,
    song_sequencer_if.slave   bus,
    output logic [31:0]       song,
    output logic              busy
);
    localparam int IW = $clog2(EVENT_DEPTH);

    logic [31:0]       mem [EVENT_DEPTH];
    seq_state_t        state, state_n;
    evt_t              evt_q;
    logic [15:0]       dur_cnt;
    logic [IW-1:0]     index;
    logic              play, loop_en;
    logic [TICK_W-1:0] tick_period;
    logic              tick, tg_clr;
    logic              adv_raw, adv;
    logic              reg0_wr, tick_wr, stop_wr, start_wr;

    assign reg0_wr  = bus.ctrl_write && (bus.ctrl_address == CTRL_REG);
    assign tick_wr  = bus.ctrl_write && (bus.ctrl_address == TICK_REG);
    assign stop_wr  = (reg0_wr && !bus.ctrl_writedata[0])
                   || (bus.ctrl_write && (bus.ctrl_address == ABORT_REG));
    assign start_wr = reg0_wr && bus.ctrl_writedata[0] && (state == IDLE);
    assign adv      = adv_raw && !stop_wr;
    assign busy     = (state != IDLE);

    tick_gen #(.W(TICK_W)) u_tick (
        .CLK    (CLK),
        .RESET_N(RESET_N),
        .clr    (tg_clr),
        .en     (state == WAIT),
        .period (tick_period),
        .tick   (tick)
    );

    always_ff @(posedge CLK) begin
        if (bus.evt_write) begin
            mem[bus.evt_address] <= bus.evt_writedata;
        end
    end

    assign bus.evt_readdata = mem[bus.evt_address];

    always_comb begin
        bus.ctrl_readdata = '0;
        unique case (bus.ctrl_address)
            CTRL_REG: bus.ctrl_readdata[1:0] = {loop_en, play};
            TICK_REG: bus.ctrl_readdata[TICK_W-1:0] = tick_period;
            STAT_REG: begin
                bus.ctrl_readdata[0]       = busy;
                bus.ctrl_readdata[8 +: IW] = index;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n = state;
        tg_clr  = 1'b0;
        adv_raw = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_wr) begin
                    state_n = FETCH;
                    tg_clr  = 1'b1;
                end
            end
            FETCH: state_n = APPLY;
            APPLY: begin
                if (evt_q.dur != '0) begin
                    state_n = WAIT;
                    tg_clr  = 1'b1;
                end else begin
                    adv_raw = 1'b1;
                end
            end
            WAIT: begin
                if (tick && (dur_cnt == 16'd1)) adv_raw = 1'b1;
            end
            default: state_n = IDLE;
        endcase
        if (adv_raw) begin
            state_n = (evt_q.last && !loop_en) ? IDLE : FETCH;
        end
        if (stop_wr) state_n = IDLE;
    end

    // Later assignments override earlier ones: apply < advance < stop.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            song        <= '0;
            index       <= '0;
            evt_q       <= '0;
            dur_cnt     <= '0;
            play        <= 1'b0;
            loop_en     <= 1'b0;
            tick_period <= '0;
        end else begin
            if (reg0_wr) begin
                play    <= bus.ctrl_writedata[0];
                loop_en <= bus.ctrl_writedata[1];
            end
            if (tick_wr) tick_period <= bus.ctrl_writedata[TICK_W-1:0];
            unique case (state)
                IDLE: begin
                    if (start_wr) begin
                        index <= '0;
                        song  <= '0;
                    end
                end
                FETCH: evt_q <= unpack_evt(mem[index]);
                APPLY: begin
                    song[{evt_q.slot, 3'b000} +: 8] <= evt_q.key;
                    if (evt_q.dur != '0) dur_cnt <= evt_q.dur;
                end
                WAIT: begin
                    if (tick) dur_cnt <= dur_cnt - 16'd1;
                end
                default: ;
            endcase
            if (adv) begin
                if (!evt_q.last) begin
                    index <= index + IW'(1);
                end else begin
                    song <= '0;
                    if (loop_en) index <= '0;
                    else         play  <= 1'b0;
                end
            end
            if (stop_wr) begin
                song <= '0;
                play <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_song_sequencer.sv
// Scoreboard bench for song_sequencer: event-timeline model feeds a queue,
// a negedge monitor checks every song change against it.
module tb_song_sequencer;
    import audio_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET_N = 1'b0;
    logic [31:0] song;
    logic        busy;

    song_sequencer_if #(.AW(6)) bus();

    song_sequencer #(.EVENT_DEPTH(64), .TICK_W(24)) dut (
        .CLK    (CLK),
        .RESET_N(RESET_N),
        .bus    (bus),
        .song   (song),
        .busy   (busy)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    typedef struct {
        int          e;
        logic [31:0] v;
    } exp_t;

    exp_t        exp_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] mem_m [64];
    bit          mon_en = 0;
    logic [31:0] last_song = '0;
    logic [31:0] m_prev;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (edge %0d)",
                     name, act, req, cyc);
        end
    endtask

    always @(negedge CLK) begin : monitor
        exp_t x;
        if (mon_en && RESET_N && song !== last_song) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL song_unexpected: got %h at edge %0d", song, cyc);
            end else begin
                x = exp_q.pop_front();
                if (x.v !== song || x.e != cyc) begin
                    n_fail++;
                    $display("FAIL song_change: got %h at edge %0d required %h at edge %0d",
                             song, cyc, x.v, x.e);
                end
            end
            last_song = song;
        end
    end

    function automatic void push(input int e, input logic [31:0] v);
        exp_t x;
        if (v !== m_prev) begin
            x.e = e;
            x.v = v;
            exp_q.push_back(x);
            m_prev = v;
        end
    endfunction

    // Timeline of the note list: play sampled at edge n, host stop at edge h.
    // Returns the natural end edge, or -1 when the stop cuts it short.
    function automatic int model(input int n, input int h, input int p,
                                 input bit lp);
        int e = n;
        int idx = 0;
        int pp = (p == 0) ? 1 : p;
        int dur;
        logic [31:0] s = '0;
        logic [31:0] w;
        m_prev = '0;
        while (1) begin
            e += 2;
            if (e >= h) break;
            w = mem_m[idx];
            s[int'(w[9:8]) * 8 +: 8] = w[7:0];
            dur = int'(w[31:16]);
            if (dur != 0) begin
                push(e, s);
                e += dur * pp;
                if (e >= h) break;
            end
            if (w[10]) begin
                s = '0;
                push(e, s);
                if (!lp) return e;
                idx = 0;
            end else begin
                push(e, s);
                idx = (idx + 1) % 64;
            end
        end
        push(h, '0);
        return -1;
    endfunction

    task automatic evt_wr(input int a, input logic [31:0] d);
        bus.evt_address   = 6'(a);
        bus.evt_writedata = d;
        bus.evt_write     = 1'b1;
        mem_m[a]          = d;
        @(negedge CLK);
        bus.evt_write     = 1'b0;
    endtask

    task automatic ctrl_wr(input logic [1:0] a, input logic [31:0] d);
        bus.ctrl_address   = a;
        bus.ctrl_writedata = d;
        bus.ctrl_write     = 1'b1;
        @(negedge CLK);
        bus.ctrl_write     = 1'b0;
    endtask

    task automatic read_ctrl(input logic [1:0] a, output logic [31:0] d);
        bus.ctrl_address = a;
        #1;
        d = bus.ctrl_readdata;
    endtask

    task automatic run_case(input int p, input bit lp, input int hrel,
                            input bit use_abort, input bit wrap);
        int n, h, fin, k;
        logic [31:0] rd;
        ctrl_wr(TICK_REG, 32'(p));
        n = cyc + 1;
        h = (hrel > 0) ? n + hrel : 32'h7fff_ffff;
        fin = model(n, h, p, lp);
        ctrl_wr(CTRL_REG, {30'd0, lp, 1'b1});
        if (fin < 0) begin
            while (cyc < h - 1) begin
                if (wrap && cyc > n && (cyc - n) % 3 == 0) begin
                    k = ((cyc - n) / 3) % 64;
                    if (k >= 62 || k <= 1) begin
                        read_ctrl(STAT_REG, rd);
                        check("status_index", rd, 32'((k << 8) | 1));
                    end
                end
                @(negedge CLK);
            end
            if (use_abort) ctrl_wr(ABORT_REG, 32'hdead_beef);
            else           ctrl_wr(CTRL_REG, {30'd0, lp, 1'b0});
            check("busy_after_stop", 32'(busy), 32'd0);
        end else begin
            while (cyc < fin - 1) @(negedge CLK);
            check("busy_before_end", 32'(busy), 32'd1);
            @(negedge CLK);
            check("busy_at_end", 32'(busy), 32'd0);
        end
        read_ctrl(CTRL_REG, rd);
        check("play_readback", 32'(rd[0]), 32'd0);
        repeat (4) @(negedge CLK);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish (edge %0d)", cyc);
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int nev;
        bit lp;
        int hrel;
        bus.evt_address    = '0;
        bus.evt_write      = 1'b0;
        bus.evt_writedata  = '0;
        bus.ctrl_address   = '0;
        bus.ctrl_write     = 1'b0;
        bus.ctrl_writedata = '0;
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);

        check("rst_song", song, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        read_ctrl(CTRL_REG, rd);
        check("rst_ctrl", rd, 32'd0);
        read_ctrl(TICK_REG, rd);
        check("rst_tick", rd, 32'd0);
        read_ctrl(STAT_REG, rd);
        check("rst_status", rd, 32'd0);

        evt_wr(0, 32'h0003_0404);
        evt_wr(5, 32'hcafe_1234);
        bus.evt_address = 6'd0;
        #1 check("evt_read0", bus.evt_readdata, mem_m[0]);
        bus.evt_address = 6'd5;
        #1 check("evt_read5", bus.evt_readdata, mem_m[5]);
        @(negedge CLK);

        ctrl_wr(TICK_REG, 32'd2);
        ctrl_wr(CTRL_REG, 32'd1);
        repeat (4) @(negedge CLK);
        check("pre_rst_song", song, 32'h0000_0004);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2 RESET_N = 1'b0;
        #1;
        check("async_rst_song", song, 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        read_ctrl(CTRL_REG, rd);
        check("async_rst_ctrl", rd, 32'd0);
        read_ctrl(TICK_REG, rd);
        check("async_rst_tick", rd, 32'd0);
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        bus.evt_address = 6'd0;
        #1 check("mem_kept", bus.evt_readdata, 32'h0003_0404);
        @(negedge CLK);

        last_song = song;
        mon_en = 1;

        run_case(2, 0, 0, 0, 0);

        evt_wr(0, 32'h0000_0004);
        evt_wr(1, 32'h0000_0116);
        evt_wr(2, 32'h0002_0607);
        run_case(1, 0, 0, 0, 0);
        run_case(0, 0, 0, 0, 0);

        evt_wr(0, 32'h0003_0404);
        run_case(2, 1, 40, 1, 0);

        evt_wr(0, 32'h0001_0521);
        run_case(1, 1, 3, 0, 0);

        for (int i = 0; i < 64; i++) begin
            evt_wr(i, {16'd1, 5'($urandom), 1'b0, 2'($urandom),
                       8'($urandom_range(1, 255))});
        end
        run_case(1, 0, 3 * 66 + 5, 1, 1);

        repeat (16) begin
            nev = $urandom_range(1, 5);
            for (int i = 0; i < nev; i++) begin
                evt_wr(i, {16'($urandom_range(0, 3)), 5'($urandom),
                           (i == nev - 1), 2'($urandom), 8'($urandom)});
            end
            lp = 1'($urandom);
            if (lp) hrel = $urandom_range(3, 80);
            else    hrel = $urandom_range(0, 1) ? $urandom_range(3, 40) : 0;
            run_case($urandom_range(0, 3), lp, hrel, 1'($urandom), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
